execute_cycle: RTL and testbench

Execute stage of the five-stage RISC-V pipeline. Consumes the ID/EX fields the decode stage registers, resolves operand forwarding, runs the 3-bit-coded ALU, and computes branch target and branch-taken. Registers the EX/MEM pipeline fields, with stall and bubble-insertion control driven by the hazard logic.

---
 rtl/execute_cycle_if.sv | 61 ++++++
 rtl/execute_cycle.sv | 115 +++++++++++
 tb/tb_execute_cycle.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/execute_cycle_if.sv
// EX-stage port bundle: ID/EX fields, writeback forwarding bus,
// hazard controls and the EX/MEM outputs.
interface execute_cycle_if #(
    parameter int XLEN = 32
);
    logic            ValidE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            ResultSrcE;
    logic            ALUSrcE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic            RegWriteW;
    logic [4:0]      RDW;
    logic [XLEN-1:0] ResultW;
    logic            StallM;
    logic            FlushM;
    logic            ZeroE;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [4:0]      RdM;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            ResultSrcM;
    logic            ValidM;

    modport master (
        output ValidE, RegWriteE, MemWriteE, ResultSrcE,
        output ALUSrcE, BranchE, ALUControlE,
        output RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E,
        output Rs1E, Rs2E, RdE,
        output RegWriteW, RDW, ResultW,
        output StallM, FlushM,
        input  ZeroE, PCSrcE, PCTargetE,
        input  ALUResultM, WriteDataM, PCPlus4M,
        input  RdM, RegWriteM, MemWriteM, ResultSrcM, ValidM
    );

    modport slave (
        input  ValidE, RegWriteE, MemWriteE, ResultSrcE,
        input  ALUSrcE, BranchE, ALUControlE,
        input  RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E,
        input  Rs1E, Rs2E, RdE,
        input  RegWriteW, RDW, ResultW,
        input  StallM, FlushM,
        output ZeroE, PCSrcE, PCTargetE,
        output ALUResultM, WriteDataM, PCPlus4M,
        output RdM, RegWriteM, MemWriteM, ResultSrcM, ValidM
    );
endinterface

// File: rtl/execute_cycle.sv
// RISC-V execute stage: forwarding, ALU, branch resolve, EX/MEM register.
// Define EXEC_FORWARD_EN to enable the MEM/WB forwarding network.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst,
    execute_cycle_if.slave ex_if
);
    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rd;
        logic            rw;
        logic            mw;
        logic            rs;
        logic            v;
    } exm_t;

    exm_t m_q;
    exm_t m_d;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;

`ifdef EXEC_FORWARD_EN
    logic mem_ok;
    logic wb_ok;

    // Loads in MEM are excluded: their data is not ready until WB.
    assign mem_ok = m_q.v & m_q.rw & ~m_q.rs & (m_q.rd != 5'd0);
    assign wb_ok  = ex_if.RegWriteW & (ex_if.RDW != 5'd0);

    always_comb begin
        src_a = ex_if.RD1_E;
        if (mem_ok && m_q.rd == ex_if.Rs1E)
            src_a = m_q.alu;
        else if (wb_ok && ex_if.RDW == ex_if.Rs1E)
            src_a = ex_if.ResultW;
    end

    always_comb begin
        src_b = ex_if.RD2_E;
        if (mem_ok && m_q.rd == ex_if.Rs2E)
            src_b = m_q.alu;
        else if (wb_ok && ex_if.RDW == ex_if.Rs2E)
            src_b = ex_if.ResultW;
    end
`else
    logic unused_fwd;

    assign src_a      = ex_if.RD1_E;
    assign src_b      = ex_if.RD2_E;
    assign unused_fwd = ^{ex_if.Rs1E, ex_if.Rs2E, ex_if.RegWriteW,
                          ex_if.RDW, ex_if.ResultW};
`endif

    assign op_b  = ex_if.ALUSrcE ? ex_if.ImmExtE : src_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        case (ex_if.ALUControlE)
            3'b000: alu_res = src_a + op_b;
            3'b001: alu_res = src_a - op_b;
            3'b010: alu_res = src_a & op_b;
            3'b011: alu_res = src_a | op_b;
            3'b100: alu_res = src_a ^ op_b;
            3'b101: alu_res = {{(XLEN-1){1'b0}},
                               $signed(src_a) < $signed(op_b)};
            3'b110: alu_res = src_a << shamt;
            3'b111: alu_res = src_a >> shamt;
            default: alu_res = '0;
        endcase
    end

    assign ex_if.ZeroE     = (alu_res == '0);
    assign ex_if.PCSrcE    = ex_if.BranchE & ex_if.ZeroE & ex_if.ValidE;
    assign ex_if.PCTargetE = ex_if.PCE + ex_if.ImmExtE;

    // Flush beats stall; an invalid slot enters MEM as a bubble.
    always_comb begin
        m_d = m_q;
        if (ex_if.FlushM) begin
            m_d = '0;
        end else if (!ex_if.StallM) begin
            m_d.alu = alu_res;
            m_d.wd  = src_b;
            m_d.pc4 = ex_if.PCPlus4E;
            m_d.rd  = ex_if.RdE;
            m_d.rw  = ex_if.RegWriteE & ex_if.ValidE;
            m_d.mw  = ex_if.MemWriteE & ex_if.ValidE;
            m_d.rs  = ex_if.ResultSrcE & ex_if.ValidE;
            m_d.v   = ex_if.ValidE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_q <= '0;
        else     m_q <= m_d;
    end

    assign ex_if.ALUResultM = m_q.alu;
    assign ex_if.WriteDataM = m_q.wd;
    assign ex_if.PCPlus4M   = m_q.pc4;
    assign ex_if.RdM        = m_q.rd;
    assign ex_if.RegWriteM  = m_q.rw;
    assign ex_if.MemWriteM  = m_q.mw;
    assign ex_if.ResultSrcM = m_q.rs;
    assign ex_if.ValidM     = m_q.v;
endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: directed vectors push expected
// EX/MEM records; a monitor pops and compares after each rising edge.
module tb_execute_cycle;
    logic clk = 1'b0;
    logic rst = 1'b1;

`ifdef EXEC_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    execute_cycle_if #(.XLEN(32)) ex_if ();

    execute_cycle #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .ex_if (ex_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        rs;
        logic        vm;
    } mrec_t;

    mrec_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    n_rec  = 0;

    function automatic mrec_t mk(
        input logic [31:0] alu, input logic [31:0] wd,
        input logic [31:0] pc4, input logic [4:0] rd,
        input logic rw, input logic mw,
        input logic rs, input logic vm);
        mrec_t r;
        r.alu = alu; r.wd = wd; r.pc4 = pc4; r.rd = rd;
        r.rw = rw; r.mw = mw; r.rs = rs; r.vm = vm;
        return r;
    endfunction

    function automatic mrec_t cur_m();
        return mk(ex_if.ALUResultM, ex_if.WriteDataM, ex_if.PCPlus4M,
                  ex_if.RdM, ex_if.RegWriteM, ex_if.MemWriteM,
                  ex_if.ResultSrcM, ex_if.ValidM);
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_m0(input string name);
        mrec_t g;
        g = cur_m();
        n_chk++;
        if (g !== '0) begin
            n_fail++;
            $display("FAIL %s: M state %h expected all zero", name, g);
        end
    endtask

    // Monitor: one record per rising edge that has an expectation queued.
    initial begin
        mrec_t e;
        mrec_t g;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                g = cur_m();
                n_chk++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL m_rec%0d: got alu=%h wd=%h pc4=%h rd=%0d rw%b mw%b rs%b v%b expected alu=%h wd=%h pc4=%h rd=%0d rw%b mw%b rs%b v%b",
                             n_rec, g.alu, g.wd, g.pc4, g.rd, g.rw, g.mw, g.rs, g.vm,
                             e.alu, e.wd, e.pc4, e.rd, e.rw, e.mw, e.rs, e.vm);
                end
                n_rec++;
            end
        end
    end

    task automatic idle();
        ex_if.ValidE = 0; ex_if.RegWriteE = 0; ex_if.MemWriteE = 0;
        ex_if.ResultSrcE = 0; ex_if.ALUSrcE = 0; ex_if.BranchE = 0;
        ex_if.ALUControlE = 3'b000;
        ex_if.RD1_E = 0; ex_if.RD2_E = 0; ex_if.ImmExtE = 0;
        ex_if.PCE = 0; ex_if.PCPlus4E = 0;
        ex_if.Rs1E = 0; ex_if.Rs2E = 0; ex_if.RdE = 0;
        ex_if.RegWriteW = 0; ex_if.RDW = 0; ex_if.ResultW = 0;
        ex_if.StallM = 0; ex_if.FlushM = 0;
    endtask

    task automatic step(input mrec_t e);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_nochk();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] sweep [8];

    initial begin
        sweep = '{32'hFFFFFFF4, 32'hFFFFFFEC, 32'h0, 32'hFFFFFFF4,
                  32'hFFFFFFF4, 32'h1, 32'hFFFFFF00, 32'h0FFFFFFF};
        idle();
        @(posedge clk);
        @(negedge clk);
        chk_m0("reset_state");
        rst = 1'b0;

        // One real instruction, then asynchronous reset mid-cycle
        ex_if.ValidE = 1; ex_if.RegWriteE = 1; ex_if.RdE = 3;
        ex_if.RD1_E = 1; ex_if.RD2_E = 2; ex_if.PCPlus4E = 32'h104;
        step(mk(32'd3, 32'd2, 32'h104, 5'd3, 1, 0, 0, 1));
        #2 rst = 1'b1;
        #1 chk_m0("async_reset");
        #1 rst = 1'b0;
        idle();
        step_nochk();

        // ALU sweep
        ex_if.ValidE = 1; ex_if.RegWriteE = 1; ex_if.RdE = 7;
        ex_if.RD1_E = 32'hFFFFFFF0; ex_if.RD2_E = 32'h4;
        ex_if.PCPlus4E = 32'h200;
        for (int i = 0; i < 8; i++) begin
            ex_if.ALUControlE = 3'(i);
            #1 chk($sformatf("zero_op%0d", i), 32'(ex_if.ZeroE),
                   32'(sweep[i] == 0));
            step(mk(sweep[i], 32'h4, 32'h200, 5'd7, 1, 0, 0, 1));
        end

        // Branch taken / invalid slot
        idle();
        ex_if.ValidE = 1; ex_if.BranchE = 1; ex_if.ALUControlE = 3'b001;
        ex_if.RD1_E = 5; ex_if.RD2_E = 5; ex_if.PCE = 32'h100;
        ex_if.ImmExtE = 32'hFFFFFFF8; ex_if.PCPlus4E = 32'h104;
        #1;
        chk("br_zero", 32'(ex_if.ZeroE), 32'd1);
        chk("br_pcsrc", 32'(ex_if.PCSrcE), 32'd1);
        chk("br_target", ex_if.PCTargetE, 32'hF8);
        step(mk(32'h0, 32'h5, 32'h104, 5'd0, 0, 0, 0, 1));
        ex_if.ValidE = 0;
        #1 chk("br_invalid_pcsrc", 32'(ex_if.PCSrcE), 32'd0);
        step(mk(32'h0, 32'h5, 32'h104, 5'd0, 0, 0, 0, 0));

        // Forward priority
        idle();
        ex_if.ValidE = 1; ex_if.RegWriteE = 1; ex_if.ALUSrcE = 1;
        ex_if.RdE = 5; ex_if.RD1_E = 32'h11; ex_if.PCPlus4E = 32'h300;
        step(mk(32'h11, 32'h0, 32'h300, 5'd5, 1, 0, 0, 1));
        ex_if.Rs1E = 5; ex_if.RegWriteW = 1; ex_if.RDW = 5;
        ex_if.ResultW = 32'h22; ex_if.RD1_E = 32'h33; ex_if.ResultSrcE = 1;
        step(mk(FWD ? 32'h11 : 32'h33, 32'h0, 32'h300, 5'd5, 1, 0, 1, 1));
        ex_if.Rs2E = 5; ex_if.RD2_E = 32'h44; ex_if.RdE = 6;
        ex_if.ResultSrcE = 0;
        step(mk(FWD ? 32'h22 : 32'h33, FWD ? 32'h22 : 32'h44,
                32'h300, 5'd6, 1, 0, 0, 1));
        ex_if.Rs1E = 0; ex_if.Rs2E = 0; ex_if.RDW = 0; ex_if.RdE = 0;
        ex_if.RD1_E = 32'h55; ex_if.RD2_E = 32'h0;
        step(mk(32'h55, 32'h0, 32'h300, 5'd0, 1, 0, 0, 1));
        ex_if.RD1_E = 32'h66;
        step(mk(32'h66, 32'h0, 32'h300, 5'd0, 1, 0, 0, 1));

        // Stall and flush
        idle();
        ex_if.ValidE = 1; ex_if.MemWriteE = 1; ex_if.RdE = 9;
        ex_if.RD1_E = 32'hA; ex_if.RD2_E = 32'h3; ex_if.PCPlus4E = 32'h404;
        step(mk(32'hD, 32'h3, 32'h404, 5'd9, 0, 1, 0, 1));
        ex_if.StallM = 1; ex_if.RD1_E = 32'h100; ex_if.RdE = 2;
        ex_if.RegWriteE = 1; ex_if.PCPlus4E = 32'h500;
        step(mk(32'hD, 32'h3, 32'h404, 5'd9, 0, 1, 0, 1));
        step(mk(32'hD, 32'h3, 32'h404, 5'd9, 0, 1, 0, 1));
        ex_if.FlushM = 1;
        step(mk(32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0));

        // Invalid slot with control bits set leaves as a bubble
        idle();
        ex_if.RegWriteE = 1; ex_if.MemWriteE = 1; ex_if.ResultSrcE = 1;
        ex_if.RD1_E = 7; ex_if.RD2_E = 1; ex_if.RdE = 3;
        ex_if.PCPlus4E = 32'h604;
        step(mk(32'h8, 32'h1, 32'h604, 5'd3, 0, 0, 0, 0));

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
